button_event: RTL
=================

# button_event

Converts the debounced push-button level into single-cycle event pulses and a held level for the FPGA board front end. It sits directly downstream of the debouncer and feeds the CPU step/run control and the display-mode logic. It reports press, release, long-press and optional auto-repeat events, so consumers never need to edge-detect themselves.

## Interface
- `LONG_CYCLES`, default 50_000_000: cycles the button must stay held after the press pulse before `long_press` fires; must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period once in long-press; must be ≥ 2.
- `CNT_WIDTH`, default 26: counter width; must hold max(`LONG_CYCLES`, `REPEAT_CYCLES`) − 1.

- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `btn` in 1: debounced button level, synchronous to `clk`; 1 = pressed.
- `press` out 1: one-cycle pulse on a new press.
- `release` out 1: one-cycle pulse when a press ends.
- `long_press` out 1: one-cycle pulse when a hold reaches `LONG_CYCLES`.
- `repeat_pulse` out 1: one-cycle auto-repeat pulse while in long-press; constant 0 without the macro.
- `held` out 1: level, 1 from the `press` cycle through the cycle before `release`.

## Operation
- All outputs are registered. Reset value of every output is 0, state is `WAIT_LOW` and count is 0.
- States:
  - `WAIT_LOW`: `btn`=0 → `IDLE`. Otherwise stay. No events fire here. This state blocks phantom presses when the button is held through reset.
  - `IDLE`: `btn`=1 → `PRESSED`, count←0, `press`←1.
  - `PRESSED`:
    - `btn`=0 → `IDLE`, `release`←1.
    - else count==`LONG_CYCLES`−1 → `LONG`, count←0, `long_press`←1.
    - else count←count+1.
  - `LONG`:
    - `btn`=0 → `IDLE`, `release`←1.
    - else, with the macro: if count==`REPEAT_CYCLES`−1, then `repeat_pulse`←1 and count←0; otherwise count←count+1.
    - else, without the macro: count holds.
- `held` = (state is `PRESSED` or `LONG`), registered.
- At most one event pulse is asserted per cycle. `release` has priority over `long_press` and `repeat_pulse` when they coincide.
- The counter never wraps: it is always cleared at its terminal value or on a state change.

## Timing
- Edge 0 is the first edge that samples `btn`=1 in `IDLE`.
  - `press` and `held` go high after edge 0.
  - `long_press` is high for the cycle after edge `LONG_CYCLES`.
  - `repeat_pulse` is high after edges `LONG_CYCLES`+k·`REPEAT_CYCLES`, for k ≥ 1.
- `release` is high for the cycle after the first edge that samples `btn`=0. `held` drops at that same edge.
- A one-cycle `btn` high in `IDLE` produces `press` followed immediately by `release`.
- Mid-operation reset: outputs drop asynchronously and the block enters `WAIT_LOW`. No `release` is emitted for the aborted press.

## Configuration
- `BUTTON_EVT_REPEAT_EN` defined:
  - the repeat counter logic is compiled in;
  - `repeat_pulse` fires every `REPEAT_CYCLES` while in `LONG`.
- Not defined:
  - the repeat logic is removed;
  - `repeat_pulse` is tied to 0;
  - the count is frozen in `LONG`;
  - all other behaviour is identical.

## Test plan
All scenarios use `LONG_CYCLES`=8, `REPEAT_CYCLES`=4 and `CNT_WIDTH`=4.
- Basic press: reset, then `btn`=0 for 3 cycles; all outputs 0. Raise `btn` before edge 0 → `press` for exactly 1 cycle after edge 0; `held`=1 from then on.
- Short press: `btn` high for edges 0–4, low at edge 5 → one `press`, one `release` after edge 5, no `long_press`, `held` back to 0 after edge 5.
- Long press with macro: `btn` high for edges 0–19, low at edge 20 →
  - `long_press` after edge 8;
  - `repeat_pulse` after edges 12 and 16;
  - `release` after edge 20, with no repeat at edge 20.
- Boundary: `btn` drops exactly at edge 8 → `release` after edge 8, `long_press` never asserted.
- Reset mid-hold: assert `reset` after edge 5 while `btn`=1 → all outputs 0 immediately. Deassert with `btn` still 1 for 10 cycles → no events. Drop `btn` for 1 cycle, then raise it → `press` fires.
- Without `BUTTON_EVT_REPEAT_EN`: the long-press scenario gives `long_press` after edge 8, `repeat_pulse`=0 throughout, and `release` after edge 20.

Source files
------------

// File: rtl/button_event.sv
//-----------------------------------------------------------------------------
// Module      : button_event
// Description : Turns the debounced push-button level into single-cycle event
//               pulses (press, release, long press, optional auto-repeat) and
//               a registered "held" level.
//
// Parameters  : LONG_CYCLES   - cycles held after the press pulse before
//                               long_press fires (>= 2)
//               REPEAT_CYCLES - auto-repeat period while in long press (>= 2)
//               CNT_WIDTH     - counter width, must hold
//                               max(LONG_CYCLES, REPEAT_CYCLES) - 1
// Ports       : clk           - system clock, rising edge
//               reset         - asynchronous active-high reset
//               btn           - debounced button level, 1 = pressed
//               press         - one-cycle pulse on a new press
//               release_pulse - one-cycle pulse when a press ends
//               long_press    - one-cycle pulse when a hold reaches LONG_CYCLES
//               repeat_pulse  - one-cycle auto-repeat pulse while in long press
//               held          - level, high from the press cycle through the
//                               cycle before release_pulse
// Macro       : BUTTON_EVT_REPEAT_EN - compiles in the auto-repeat logic; when
//               undefined repeat_pulse is tied to 0 and the count is frozen in
//               the long-press state.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module button_event #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_WIDTH     = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  // Elaboration-time parameter sanity check.
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_event: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_long_last = CNT_WIDTH'(LONG_CYCLES - 1);
`ifdef BUTTON_EVT_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] c_rep_last  = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_next;

  logic r_press, r_release, r_long, r_repeat, r_held;
  logic w_press, w_release, w_long, w_repeat, w_held;

  // Next-state, next-count and next-output logic. Every output is the
  // registered version of the decision made here, so each event is exactly
  // one cycle wide and only one event can be chosen per cycle.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_press      = 1'b0;
    w_release    = 1'b0;
    w_long       = 1'b0;
    w_repeat     = 1'b0;

    case (r_state)
      // Entered from reset; a button held through reset must be released
      // before a press can be reported.
      WAIT_LOW: begin
        if (!btn) begin
          w_state_next = IDLE;
        end
      end

      IDLE: begin
        if (btn) begin
          w_state_next = PRESSED;
          w_count_next = c_cnt_zero;
          w_press      = 1'b1;
        end
      end

      PRESSED: begin
        if (!btn) begin
          w_state_next = IDLE;
          w_count_next = c_cnt_zero;
          w_release    = 1'b1;
        end else if (r_count == c_long_last) begin
          w_state_next = LONG;
          w_count_next = c_cnt_zero;
          w_long       = 1'b1;
        end else begin
          w_count_next = r_count + c_cnt_one;
        end
      end

      LONG: begin
        if (!btn) begin
          // Release wins over a repeat landing on the same edge.
          w_state_next = IDLE;
          w_count_next = c_cnt_zero;
          w_release    = 1'b1;
        end else begin
`ifdef BUTTON_EVT_REPEAT_EN
          if (r_count == c_rep_last) begin
            w_count_next = c_cnt_zero;
            w_repeat     = 1'b1;
          end else begin
            w_count_next = r_count + c_cnt_one;
          end
`else
          w_count_next = r_count;
`endif
        end
      end

      default: begin
        w_state_next = WAIT_LOW;
        w_count_next = c_cnt_zero;
      end
    endcase

    w_held = (w_state_next == PRESSED) || (w_state_next == LONG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= WAIT_LOW;
      r_count   <= c_cnt_zero;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_held    <= w_held;
    end
  end

  assign press         = r_press;
  assign release_pulse = r_release;
  assign long_press    = r_long;
  assign repeat_pulse  = r_repeat;
  assign held          = r_held;

endmodule

`default_nettype wire
